// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//
// Front-end stage of the MIPS core. Holds the program counter, fetches one
// instruction at a time from instruction memory over a req/ack handshake,
// presents the latched word to the controller/datapath and computes the next
// PC (jump, jump-register, branch or fall-through) when the core retires the
// current instruction.
//
// Build option:
//   FETCH_MISALIGN_TRAP_EN  when defined, a misaligned next PC loads as-is,
//                           raises misalign_fault and parks the FSM in FAULT
//                           until reset. When undefined, the next PC is
//                           force-aligned and misalign_fault is tied low.
//
// Ports:
//   clk, rst_n        core clock (rising edge), async active-low reset
//   imem_req/addr     fetch request and address (addr = pc)
//   imem_ack/rdata    memory acknowledge and instruction word
//   inst, inst_valid  latched instruction and its valid flag
//   inst_take         core retires the current instruction
//   jsel/jrsel/pcsrc  next-PC selects, sampled on the take edge
//   rs_data           jump-register target
//   pc, pc_plus4      current instruction address and link value
//   misalign_fault    sticky misaligned-target flag (trap build only)
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       inst,
    output logic              inst_valid,
    input  logic              inst_take,
    input  logic              jsel,
    input  logic              jrsel,
    input  logic              pcsrc,
    input  logic [ADDR_W-1:0] rs_data,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus4,
    output logic              misalign_fault
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        VALID = 2'd2
`ifdef FETCH_MISALIGN_TRAP_EN
        ,
        FAULT = 2'd3
`endif
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [31:0]       inst_q, inst_d;
    logic              inst_valid_q, inst_valid_d;
    logic [ADDR_W-1:0] pc_plus4_w;
    logic [ADDR_W-1:0] next_pc;

    // Modulo-2^ADDR_W: FFFF_FFFC + 4 wraps to 0 silently.
    assign pc_plus4_w = pc_q + ADDR_W'(4);

    // Next-PC priority: jr, j, taken branch, fall-through. jrsel alone (without
    // jsel) does not select the register target.
    always_comb begin
        if (jsel && jrsel) begin
            next_pc = rs_data;
        end else if (jsel) begin
            next_pc = {pc_plus4_w[ADDR_W-1:28], inst_q[25:0], 2'b00};
        end else if (pcsrc) begin
            next_pc = pc_plus4_w + {{(ADDR_W-18){inst_q[15]}}, inst_q[15:0], 2'b00};
        end else begin
            next_pc = pc_plus4_w;
        end
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    logic fault_q, fault_d;
`endif

    always_comb begin
        // NOTE: every variable gets its hold value first so no path through
        // the case leaves one unassigned, which would infer a latch.
        state_d      = state_q;
        pc_d         = pc_q;
        inst_d       = inst_q;
        inst_valid_d = inst_valid_q;
`ifdef FETCH_MISALIGN_TRAP_EN
        fault_d      = fault_q;
`endif
        case (state_q)
            IDLE: begin
                state_d = REQ;
            end
            REQ: begin
                if (imem_ack) begin
                    inst_d       = imem_rdata;
                    inst_valid_d = 1'b1;
                    state_d      = VALID;
                end
            end
            VALID: begin
                if (inst_take) begin
                    inst_valid_d = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
                    // The faulting target is still loaded so the core can
                    // report which address was bad.
                    pc_d = next_pc;
                    if (next_pc[1:0] != 2'b00) begin
                        fault_d = 1'b1;
                        state_d = FAULT;
                    end else begin
                        state_d = REQ;
                    end
`else
                    pc_d    = next_pc & ~ADDR_W'(3);
                    state_d = REQ;
`endif
                end
            end
`ifdef FETCH_MISALIGN_TRAP_EN
            FAULT: begin
                state_d = FAULT;
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of every other flop, independent of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            pc_q         <= RESET_PC;
            inst_q       <= '0;
            inst_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            inst_q       <= inst_d;
            inst_valid_q <= inst_valid_d;
        end
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= fault_d;
        end
    end
    assign misalign_fault = fault_q;
`else
    assign misalign_fault = 1'b0;
`endif

    // imem_req is a pure decode of the state register, so it drops to 0 the
    // instant reset asserts.
    assign imem_req   = (state_q == REQ);
    assign imem_addr  = pc_q;
    assign inst       = inst_q;
    assign inst_valid = inst_valid_q;
    assign pc         = pc_q;
    assign pc_plus4   = pc_plus4_w;

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Front-end stage of the MIPS core. It holds the program counter and fetches each instruction from instruction memory over a req/ack handshake. It presents the instruction word to the decoder and datapath, and computes the next PC from the decoder's jump, jump-register and branch selects when the core retires the instruction. `opcode = inst[31:26]` and `func = inst[5:0]` feed the controller directly.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded by reset.
- `ADDR_W`, default 32: PC/address width, fixed at 32 for this core.
- `clk` in 1: core clock, rising edge.
- `rst_n` in 1: reset; one clock; reset is asynchronous and active-low.
- `imem_req` out 1: fetch request; held until acknowledged.
- `imem_addr` out 32: fetch address; equals `pc` while `imem_req` = 1.
- `imem_ack` in 1: memory returns `imem_rdata` this cycle.
- `imem_rdata` in 32: instruction word.
- `inst` out 32: latched instruction to the controller and datapath.
- `inst_valid` out 1: `inst` holds the instruction at `pc`.
- `inst_take` in 1: core retires the current instruction this cycle.
- `jsel`, `jrsel`, `pcsrc` in 1 each: next-PC selects from the controller, sampled on the take edge.
- `rs_data` in 32: register-file rs value, the jump-register target.
- `pc` out 32: address of the current instruction.
- `pc_plus4` out 32: `pc + 4`, the link value for jal.
- `misalign_fault` out 1: see Configuration.

## Operation
- FSM states: IDLE, REQ, VALID, FAULT.
- **IDLE**: the state entered under reset. It moves to REQ on the first clock edge after `rst_n` deasserts.
- **REQ**:
  - Drives `imem_req` = 1 and `imem_addr` = `pc`.
  - On an edge where `imem_ack` = 1, it latches `inst` <= `imem_rdata`, sets `inst_valid` = 1 and moves to VALID.
- **VALID**:
  - `inst` is stable and `imem_req` = 0.
  - On an edge where `inst_take` = 1, `pc` <= `next_pc`, `inst_valid` <= 0, and the FSM moves to REQ.
- **next_pc** priority, evaluated on the take edge:
  1. `jsel & jrsel`: `rs_data`.
  2. `jsel`: `{pc_plus4[31:28], inst[25:0], 2'b00}`.
  3. `pcsrc`: `pc_plus4 + ({{14{inst[15]}}, inst[15:0], 2'b00})`.
  4. Otherwise: `pc_plus4`.
- **Arithmetic**: all additions are 32-bit modulo 2^32, so `pc` = FFFF_FFFC advances to 0000_0000 with no flag.
- **Boundary and ignored inputs**:
  - `inst_take` outside VALID is ignored.
  - `imem_ack` outside REQ is ignored.
  - `jsel`/`jrsel`/`pcsrc` are don't-care except on the take edge.
- **Reset** (`rst_n` low at any time, including mid-REQ):
  - Immediately forces IDLE and `pc` = RESET_PC.
  - Clears `inst`, `inst_valid`, `imem_req` and `misalign_fault` to 0.
  - An acknowledge arriving during reset is lost.

## Timing
- Reset values:
  - `pc` = RESET_PC, `pc_plus4` = RESET_PC + 4.
  - `inst` = 0, `inst_valid` = 0, `imem_req` = 0, `misalign_fault` = 0.
- `imem_req` rises one cycle after reset release.
- Fetch latency: `inst_valid` rises on the edge where `imem_req & imem_ack`, i.e. the cycle after the ack cycle.
- Best-case throughput is one instruction per 2 cycles: ack in the first REQ cycle, then take in the first VALID cycle.
- `imem_addr` and `pc` stay constant for the whole REQ period; wait states are unbounded.
- `pc`, `pc_plus4` and `inst` update only on the take edge and the ack edge respectively. They are registered and glitch-free.

## Configuration
- **`FETCH_MISALIGN_TRAP_EN` defined**:
  - If `next_pc[1:0]` != 0 on a take edge, `pc` still loads the value and `misalign_fault` <= 1.
  - The FSM enters FAULT and never asserts `imem_req`.
  - Only reset leaves FAULT.
- **`FETCH_MISALIGN_TRAP_EN` undefined**:
  - `pc` <= `{next_pc[31:2], 2'b00}` (forced alignment).
  - The FAULT state is not built and `misalign_fault` is tied to 0.

## Test plan
- **Reset and sequential fetch**:
  - Stimulus: release `rst_n`; memory acks with 0-wait; `inst_take` pulsed every VALID cycle.
  - Required: `imem_addr` sequence 0, 4, 8, 12; `inst_valid` high every other cycle.
- **Wait states**:
  - Stimulus: ack delayed 3 cycles at address 0x10.
  - Required: `imem_req` held 4 cycles; `imem_addr` = 0x10 throughout; `inst` latched only on the ack edge.
- **Branch taken**:
  - Stimulus: `pc` = 0x100, `inst[15:0]` = 0xFFFE, `pcsrc` = 1 on take.
  - Required: next `imem_addr` = 0x0FC.
  - Repeat with `pcsrc` = 0: required next address 0x104.
- **Jump and jump register**:
  - Stimulus: `pc` = 0x4000_0000, `inst[25:0]` = 0x0000040, `jsel` = 1.
  - Required: next PC 0x4000_0100.
  - Then `jsel` = `jrsel` = `pcsrc` = 1 with `rs_data` = 0x0000_2000: required next PC 0x2000.
- **Misalign**:
  - Stimulus: jr with `rs_data` = 0x2002.
  - Required with the macro defined: `misalign_fault` = 1 and `imem_req` stays 0.
  - Required with the macro undefined: fetch from 0x2000.
- **Reset mid-operation**:
  - Stimulus: assert `rst_n` low during REQ with ack in the same cycle.
  - Required: `imem_req`, `inst_valid` = 0 immediately; `pc` = RESET_PC; after release, fetch restarts at RESET_PC.
